// File: rtl/speed_pkg.sv
// rtl/speed_pkg.sv - shared state encoding and widths for the speed scheduler
package speed_pkg;

  localparam int THRESH_W = 26;
  localparam int LEVEL_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/level_threshold_calc.sv
// rtl/level_threshold_calc.sv - combinational level -> clamped divider threshold
// Optional halving of the threshold when SPEED_SCHED_BOOST_EN is defined.
module level_threshold_calc
  import speed_pkg::*;
#(
  parameter logic [THRESH_W-1:0] BASE_THRESHOLD = 26'd50_000_000,
  parameter logic [THRESH_W-1:0] STEP           = 26'd4_000_000,
  parameter logic [THRESH_W-1:0] MIN_THRESHOLD  = 26'd5_000_000
) (
  input  logic [LEVEL_W-1:0]  level,
`ifdef SPEED_SCHED_BOOST_EN
  input  logic                boost,
`endif
  output logic [THRESH_W-1:0] threshold
);

  logic [29:0]         prod;
  logic [29:0]         diff;
  logic [THRESH_W-1:0] level_thr;

  // 30-bit arithmetic so a large level*STEP cannot wrap back above the floor
  always_comb begin
    prod = 30'(level) * 30'(STEP);
    diff = 30'(BASE_THRESHOLD) - prod;
    if ((prod > 30'(BASE_THRESHOLD)) || (diff < 30'(MIN_THRESHOLD))) begin
      level_thr = MIN_THRESHOLD;
    end else begin
      level_thr = diff[THRESH_W-1:0];
    end
  end

`ifdef SPEED_SCHED_BOOST_EN
  logic [THRESH_W-1:0] half_thr;

  always_comb begin
    half_thr  = level_thr >> 1;
    threshold = level_thr;
    if (boost) begin
      threshold = (half_thr < MIN_THRESHOLD) ? MIN_THRESHOLD : half_thr;
    end
  end
`else
  assign threshold = level_thr;
`endif

endmodule

// File: rtl/speed_scheduler.sv
// rtl/speed_scheduler.sv - game-speed FSM driving the threshold pulse divider
// Optional boost input enabled by SPEED_SCHED_BOOST_EN.
module speed_scheduler
  import speed_pkg::*;
#(
  parameter logic [THRESH_W-1:0] BASE_THRESHOLD  = 26'd50_000_000,
  parameter logic [THRESH_W-1:0] STEP            = 26'd4_000_000,
  parameter logic [THRESH_W-1:0] MIN_THRESHOLD   = 26'd5_000_000,
  parameter logic [7:0]          TICKS_PER_LEVEL = 8'd16,
  parameter logic [LEVEL_W-1:0]  MAX_LEVEL       = 4'd15
) (
  input  logic                default_clk,
  input  logic                reset,
  input  logic                start,
  input  logic                pause,
  input  logic                stop,
  input  logic                pulse_in,
`ifdef SPEED_SCHED_BOOST_EN
  input  logic                boost,
`endif
  output logic                div_enable,
  output logic [THRESH_W-1:0] threshold,
  output logic                tick,
  output logic [LEVEL_W-1:0]  level,
  output logic                running
);

  state_t              state;
  state_t              state_nxt;
  logic                accept;
  logic                wrap;
  logic [7:0]          tick_count;
  logic [7:0]          count_nxt;
  logic [LEVEL_W-1:0]  level_nxt;
  logic [THRESH_W-1:0] calc_thr;

  always_ff @(posedge default_clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (start && !pause) state_nxt = S_RUN;
        S_RUN:   if (pause) state_nxt = S_PAUSE;
        S_PAUSE: if (!pause) state_nxt = S_RUN;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // A pulse counts only if we stay in RUN across this edge
  always_comb begin
    accept    = (state == S_RUN) && !stop && !pause && pulse_in;
    wrap      = accept && (tick_count == (TICKS_PER_LEVEL - 8'd1));
    count_nxt = tick_count;
    level_nxt = level;
    if (stop) begin
      count_nxt = 8'd0;
      level_nxt = '0;
    end else if (wrap) begin
      count_nxt = 8'd0;
      if (level != MAX_LEVEL) level_nxt = level + 4'd1;
    end else if (accept) begin
      count_nxt = tick_count + 8'd1;
    end
  end

`ifdef SPEED_SCHED_BOOST_EN
  logic boost_act;
  assign boost_act = boost && (state_nxt == S_RUN);

  level_threshold_calc #(
    .BASE_THRESHOLD (BASE_THRESHOLD),
    .STEP           (STEP),
    .MIN_THRESHOLD  (MIN_THRESHOLD)
  ) u_calc (
    .level     (level_nxt),
    .boost     (boost_act),
    .threshold (calc_thr)
  );
`else
  level_threshold_calc #(
    .BASE_THRESHOLD (BASE_THRESHOLD),
    .STEP           (STEP),
    .MIN_THRESHOLD  (MIN_THRESHOLD)
  ) u_calc (
    .level     (level_nxt),
    .threshold (calc_thr)
  );
`endif

  // Threshold tracks the level being entered, so it changes on the same edge
  always_ff @(posedge default_clk) begin
    if (reset) begin
      tick       <= 1'b0;
      level      <= '0;
      tick_count <= 8'd0;
      threshold  <= BASE_THRESHOLD;
    end else begin
      tick       <= accept;
      level      <= level_nxt;
      tick_count <= count_nxt;
      threshold  <= calc_thr;
    end
  end

  assign running    = (state == S_RUN);
  assign div_enable = (state == S_RUN);

endmodule

// File: tb/tb_speed_scheduler.sv
// tb/tb_speed_scheduler.sv - directed self-checking bench with a threshold divider model
module tb_speed_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        stop = 1'b0;
  logic        pulse_in;
  logic        boost = 1'b0;
  logic        div_enable;
  logic [25:0] threshold;
  logic        tick;
  logic [3:0]  level;
  logic        running;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  speed_scheduler #(
    .BASE_THRESHOLD  (26'd10),
    .STEP            (26'd2),
    .MIN_THRESHOLD   (26'd4),
    .TICKS_PER_LEVEL (8'd3),
    .MAX_LEVEL       (4'd5)
  ) dut (
    .default_clk (clk),
    .reset       (reset),
    .start       (start),
    .pause       (pause),
    .stop        (stop),
    .pulse_in    (pulse_in),
`ifdef SPEED_SCHED_BOOST_EN
    .boost       (boost),
`endif
    .div_enable  (div_enable),
    .threshold   (threshold),
    .tick        (tick),
    .level       (level),
    .running     (running)
  );

  // Divider: registered pulse every `threshold` cycles, cleared while disabled
  logic [25:0] div_cnt;
  logic        div_pulse;
  always_ff @(posedge clk) begin
    if (!div_enable) begin
      div_cnt   <= 26'd0;
      div_pulse <= 1'b0;
    end else if (div_cnt >= threshold - 26'd1) begin
      div_cnt   <= 26'd0;
      div_pulse <= 1'b1;
    end else begin
      div_cnt   <= div_cnt + 26'd1;
      div_pulse <= 1'b0;
    end
  end
  assign pulse_in = div_pulse;

  task automatic run_ticks(input int n, output bit ok);
    int seen;
    int budget;
    seen = 0;
    budget = 0;
    ok = 1'b1;
    while (seen < n) begin
      @(negedge clk);
      budget++;
      if (tick) seen++;
      if (budget > 200 * n) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic cycles_to_tick(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (tick) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    stop  = 1'b0;
    boost = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL reset_running got %0b want 0", running); end
    n_checks++; if (div_enable !== 1'b0) begin n_fail++; $display("FAIL reset_div_enable got %0b want 0", div_enable); end
    n_checks++; if (threshold !== 26'd10) begin n_fail++; $display("FAIL reset_threshold got %0d want 10", threshold); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %0b want 0", tick); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
  endtask

  task automatic test_start();
    int cyc;
    do_start();
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL start_running got %0b want 1", running); end
    n_checks++; if (div_enable !== 1'b1) begin n_fail++; $display("FAIL start_div_enable got %0b want 1", div_enable); end
    n_checks++; if (threshold !== 26'd10) begin n_fail++; $display("FAIL start_threshold got %0d want 10", threshold); end
    cycles_to_tick(cyc);
    n_checks++; if (cyc !== 11) begin n_fail++; $display("FAIL start_first_tick_cycles got %0d want 11", cyc); end
  endtask

  task automatic test_progression();
    int exp_lvl [6] = '{1, 2, 3, 4, 5, 5};
    int exp_thr [6] = '{8, 6, 4, 4, 4, 4};
    bit ok;
    // One tick already consumed by test_start
    run_ticks(2, ok);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) run_ticks(3, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL prog_timeout step %0d got timeout want ticks", k); end
      n_checks++; if (level !== 4'(exp_lvl[k])) begin n_fail++; $display("FAIL prog_level ticks=%0d got %0d want %0d", 3 * (k + 1), level, exp_lvl[k]); end
      n_checks++; if (threshold !== 26'(exp_thr[k])) begin n_fail++; $display("FAIL prog_threshold ticks=%0d got %0d want %0d", 3 * (k + 1), threshold, exp_thr[k]); end
    end
  endtask

  task automatic test_pause();
    int ticks_seen;
    int en_seen;
    int cyc;
    pause = 1'b1;
    ticks_seen = 0;
    en_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tick) ticks_seen++;
      if (div_enable || running) en_seen++;
    end
    n_checks++; if (ticks_seen !== 0) begin n_fail++; $display("FAIL pause_ticks got %0d want 0", ticks_seen); end
    n_checks++; if (en_seen !== 0) begin n_fail++; $display("FAIL pause_enable_cycles got %0d want 0", en_seen); end
    n_checks++; if (level !== 4'd5) begin n_fail++; $display("FAIL pause_level got %0d want 5", level); end
    n_checks++; if (threshold !== 26'd4) begin n_fail++; $display("FAIL pause_threshold got %0d want 4", threshold); end
    pause = 1'b0;
    @(negedge clk);
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL resume_running got %0b want 1", running); end
    cycles_to_tick(cyc);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL resume_tick_cycles got %0d want 5", cyc); end
  endtask

  task automatic test_stop();
    bit ok;
    bit got_pulse;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    do_start();
    run_ticks(6, ok);
    n_checks++; if (!ok || level !== 4'd2) begin n_fail++; $display("FAIL stop_setup_level got %0d want 2", level); end
    got_pulse = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (pulse_in) begin
        got_pulse = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++; if (!got_pulse) begin n_fail++; $display("FAIL stop_pulse_wait got timeout want pulse"); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL stop_tick got %0b want 0", tick); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL stop_running got %0b want 0", running); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL stop_level got %0d want 0", level); end
    n_checks++; if (threshold !== 26'd10) begin n_fail++; $display("FAIL stop_threshold got %0d want 10", threshold); end
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL start_stop_running got %0b want 0", running); end
    start = 1'b1;
    pause = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pause = 1'b0;
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL start_pause_running got %0b want 0", running); end
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    do_start();
    run_ticks(9, ok);
    n_checks++; if (!ok || level !== 4'd3) begin n_fail++; $display("FAIL midrun_setup_level got %0d want 3", level); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (running !== 1'b0 || div_enable !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_enable got %0b/%0b want 0/0", running, div_enable); end
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL midrun_reset_level got %0d want 0", level); end
    n_checks++; if (threshold !== 26'd10) begin n_fail++; $display("FAIL midrun_reset_threshold got %0d want 10", threshold); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL midrun_reset_tick got %0b want 0", tick); end
  endtask

`ifdef SPEED_SCHED_BOOST_EN
  task automatic test_boost();
    bit ok;
    do_reset();
    do_start();
    boost = 1'b1;
    @(negedge clk);
    n_checks++; if (threshold !== 26'd5) begin n_fail++; $display("FAIL boost_l0 got %0d want 5", threshold); end
    boost = 1'b0;
    @(negedge clk);
    n_checks++; if (threshold !== 26'd10) begin n_fail++; $display("FAIL boost_l0_restore got %0d want 10", threshold); end
    run_ticks(3, ok);
    boost = 1'b1;
    @(negedge clk);
    n_checks++; if (!ok || threshold !== 26'd4 || level !== 4'd1) begin n_fail++; $display("FAIL boost_l1 got %0d lvl %0d want 4 lvl 1", threshold, level); end
    boost = 1'b0;
    @(negedge clk);
    n_checks++; if (threshold !== 26'd8) begin n_fail++; $display("FAIL boost_l1_restore got %0d want 8", threshold); end
    run_ticks(6, ok);
    boost = 1'b1;
    @(negedge clk);
    n_checks++; if (!ok || threshold !== 26'd4 || level !== 4'd3) begin n_fail++; $display("FAIL boost_l3 got %0d lvl %0d want 4 lvl 3", threshold, level); end
    boost = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_progression();
    test_pause();
    test_stop();
    test_reset_mid_run();
`ifdef SPEED_SCHED_BOOST_EN
    test_boost();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
